spi_slave_reg_ctrl: RTL and testbench

//  Sequences the SPI slave byte datapath into register accesses.
//  - Pops received bytes from the RX FIFO (fed by the slave shift/receive logic).
//  - Decodes a command byte, then performs burst register writes, or burst

---
 rtl/spi_slave_reg_ctrl_if.sv | 31 +++
 rtl/spi_slave_reg_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_slave_reg_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_reg_ctrl_if.sv
// Byte-level signals between the SPI slave RX/TX FIFOs, the local register bank
// and the register-access controller.
interface spi_slave_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              cs_active_i;
  logic              rx_empty_i;
  logic              rx_rd_o;
  logic [7:0]        rx_data_i;
  logic              tx_full_i;
  logic              tx_wr_o;
  logic [7:0]        tx_data_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic              reg_we_o;
  logic [7:0]        reg_wdata_o;
  logic              reg_re_o;
  logic [7:0]        reg_rdata_i;
  logic [15:0]       frm_cnt_o;

  modport slave (
    input  cs_active_i, rx_empty_i, rx_data_i, tx_full_i, reg_rdata_i,
    output rx_rd_o, tx_wr_o, tx_data_o, reg_addr_o, reg_we_o, reg_wdata_o,
           reg_re_o, frm_cnt_o
  );

  modport master (
    output cs_active_i, rx_empty_i, rx_data_i, tx_full_i, reg_rdata_i,
    input  rx_rd_o, tx_wr_o, tx_data_o, reg_addr_o, reg_we_o, reg_wdata_o,
           reg_re_o, frm_cnt_o
  );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// Turns the SPI slave byte stream into burst register writes/reads: a command
// byte selects direction and start address, following bytes are data or dummies.
module spi_slave_reg_ctrl #(
  parameter int ADDR_W   = 7,
  parameter bit AUTO_INC = 1'b1
) (
  input logic                 sclk,
  input logic                 rst,
  spi_slave_reg_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_CMD_LAT,
    S_WR_POP,
    S_WR_LAT,
    S_RD_REQ,
    S_RD_LAT,
    S_RD_PUSH,
    S_RD_DUMMY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [15:0]       frm_cnt_q, frm_cnt_d;
  logic              rx_rd, tx_wr, reg_we, reg_re;
  logic [7:0]        wdata_out;

  assign addr_next = AUTO_INC ? addr_q + ADDR_W'(1) : addr_q;

  // Strobes are Mealy outputs so a pop/push is decided against the same
  // cycle's empty/full flag; everything else is held in flops.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    frm_cnt_d = frm_cnt_q;
    rx_rd     = 1'b0;
    tx_wr     = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    wdata_out = wdata_q;
    if (state_q != S_IDLE && !bus.cs_active_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.cs_active_i) state_d = S_CMD;
        S_CMD: begin
          if (!bus.rx_empty_i) begin
            rx_rd   = 1'b1;
            state_d = S_CMD_LAT;
          end
        end
        S_CMD_LAT: begin
          addr_d    = bus.rx_data_i[ADDR_W-1:0];
          frm_cnt_d = frm_cnt_q + 16'd1;
          state_d   = bus.rx_data_i[7] ? S_RD_REQ : S_WR_POP;
        end
        S_WR_POP: begin
          if (!bus.rx_empty_i) begin
            rx_rd   = 1'b1;
            state_d = S_WR_LAT;
          end
        end
        S_WR_LAT: begin
          reg_we    = 1'b1;
          wdata_out = bus.rx_data_i;
          wdata_d   = bus.rx_data_i;
          addr_d    = addr_next;
          state_d   = S_WR_POP;
        end
        S_RD_REQ: begin
          reg_re  = 1'b1;
          state_d = S_RD_LAT;
        end
        S_RD_LAT: begin
          tx_data_d = bus.reg_rdata_i;
          state_d   = S_RD_PUSH;
        end
        S_RD_PUSH: begin
          if (!bus.tx_full_i) begin
            tx_wr   = 1'b1;
            state_d = S_RD_DUMMY;
          end
        end
        S_RD_DUMMY: begin
          // The popped dummy byte is never looked at; it only paces the burst.
          if (!bus.rx_empty_i) begin
            rx_rd   = 1'b1;
            addr_d  = addr_next;
            state_d = S_RD_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign bus.rx_rd_o     = rx_rd;
  assign bus.tx_wr_o     = tx_wr;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_we_o    = reg_we;
  assign bus.reg_wdata_o = wdata_out;
  assign bus.reg_re_o    = reg_re;
  assign bus.frm_cnt_o   = frm_cnt_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Bench for spi_slave_reg_ctrl: FIFO and register-bank models around the DUT,
// directed frame table, corner-case sequences and randomised frames.
module tb_spi_slave_reg_ctrl;
  localparam int ADDR_W = 7;
  localparam int NREG   = 1 << ADDR_W;
  localparam int NVEC   = 7;

  typedef struct packed {
    logic [7:0]      cmd;
    int              n;   // bytes following the command
    int              ne;  // register accesses expected
    logic [3:0][7:0] d;
    logic [4:0][7:0] ea;  // expected addresses
    logic [4:0][7:0] ed;  // expected write data / pushed data
  } vec_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;

  spi_slave_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_slave_reg_ctrl #(.ADDR_W(ADDR_W), .AUTO_INC(1'b1)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 sclk = ~sclk;

  int         n_cmp, n_fail;
  bit         cs_ctl, full_ctl;
  int         gap_pct, full_pct;
  logic [7:0] rxq[$];
  logic [7:0] rx_pend, rd_pend;
  logic [7:0] regs [NREG];
  logic [7:0] mregs[NREG];
  logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_tx[$];
  int         rx_pops, tx_pushes, frm_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h where nothing was expected", name, act);
  endtask

  // Acts on strobes sampled at the falling edge; they commit at the next rising edge.
  task automatic observe();
    if (bus.rx_rd_o) begin
      chk("rx_rd_while_empty", 32'(bus.rx_empty_i), 32'd0);
      rx_pops++;
      if (rxq.size() > 0) rx_pend = rxq.pop_front();
    end
    if (bus.tx_wr_o) begin
      chk("tx_wr_while_full", 32'(bus.tx_full_i), 32'd0);
      tx_pushes++;
      if (exp_tx.size() == 0) miss("tx_push_unexpected", 32'(bus.tx_data_o));
      else chk("tx_push_data", 32'(bus.tx_data_o), 32'(exp_tx.pop_front()));
    end
    if (bus.reg_we_o) begin
      regs[bus.reg_addr_o] = bus.reg_wdata_o;
      if (exp_wa.size() == 0) miss("reg_we_unexpected", 32'(bus.reg_addr_o));
      else begin
        chk("reg_we_addr", 32'(bus.reg_addr_o), 32'(exp_wa.pop_front()));
        chk("reg_we_data", 32'(bus.reg_wdata_o), 32'(exp_wd.pop_front()));
      end
    end
    if (bus.reg_re_o) begin
      rd_pend = regs[bus.reg_addr_o];
      if (exp_ra.size() == 0) miss("reg_re_unexpected", 32'(bus.reg_addr_o));
      else chk("reg_re_addr", 32'(bus.reg_addr_o), 32'(exp_ra.pop_front()));
    end
  endtask

  task automatic cycle();
    @(posedge sclk);
    #1;
    bus.cs_active_i = cs_ctl;
    bus.rx_data_i   = rx_pend;
    bus.reg_rdata_i = rd_pend;
    bus.rx_empty_i  = (rxq.size() == 0) || ($urandom_range(99) < 32'(gap_pct));
    bus.tx_full_i   = full_ctl || ($urandom_range(99) < 32'(full_pct));
    @(negedge sclk);
    if (!rst) observe();
  endtask

  task automatic clear_expect();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_tx.delete();
  endtask

  function automatic bit pending();
    return rxq.size() > 0 || exp_wa.size() > 0 || exp_ra.size() > 0 || exp_tx.size() > 0;
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] body[$]);
    int budget;
    rxq.push_back(cmd);
    foreach (body[i]) rxq.push_back(body[i]);
    cs_ctl = 1'b1;
    frm_exp++;
    budget = 400;
    while (pending() && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      miss("frame_timeout", 32'(cmd));
      clear_expect();
    end
    repeat (3) cycle();
    cs_ctl = 1'b0;
    repeat (2) cycle();
    chk("frm_cnt", 32'(bus.frm_cnt_o), 32'(frm_exp));
    rxq.delete();
  endtask

  // Reference: writes land at start+i, reads return current contents at start+i,
  // one more read than dummy bytes; addresses wrap modulo the register count.
  task automatic model_frame(input logic [7:0] cmd, input int n, output logic [7:0] body[$]);
    int a;
    a = int'(cmd) % NREG;
    body.delete();
    for (int i = 0; i < n; i++) body.push_back(8'($urandom));
    if (!cmd[7]) begin
      foreach (body[i]) begin
        exp_wa.push_back(8'(a));
        exp_wd.push_back(body[i]);
        mregs[a] = body[i];
        a = (a + 1) % NREG;
      end
    end else begin
      for (int i = 0; i <= n; i++) begin
        exp_ra.push_back(8'(a));
        exp_tx.push_back(mregs[a]);
        a = (a + 1) % NREG;
      end
    end
  endtask

  initial begin
    vec_t       tbl[NVEC];
    logic [7:0] body[$];
    logic [7:0] cmd;
    logic [7:0] bpval;
    int         p0, n;

    n_cmp = 0; n_fail = 0; rx_pops = 0; tx_pushes = 0; frm_exp = 0;
    cs_ctl = 1'b0; full_ctl = 1'b0; gap_pct = 0; full_pct = 0;
    rx_pend = 8'h00; rd_pend = 8'h00;
    for (int i = 0; i < NREG; i++) begin regs[i] = 8'h00; mregs[i] = 8'h00; end
    bus.cs_active_i = 1'b0; bus.rx_empty_i = 1'b1; bus.rx_data_i = 8'h00;
    bus.tx_full_i = 1'b0; bus.reg_rdata_i = 8'h00;

    tbl[0] = '{cmd:8'h05, n:2, ne:2, d:32'h0000B2A1, ea:40'h0000000605, ed:40'h000000B2A1};
    tbl[1] = '{cmd:8'h7F, n:2, ne:2, d:32'h00002211, ea:40'h000000007F, ed:40'h0000002211};
    tbl[2] = '{cmd:8'h10, n:2, ne:2, d:32'h00007E3C, ea:40'h0000001110, ed:40'h0000007E3C};
    tbl[3] = '{cmd:8'h90, n:2, ne:3, d:32'h0000FF00, ea:40'h0000121110, ed:40'h0000007E3C};
    tbl[4] = '{cmd:8'hFF, n:1, ne:2, d:32'h0000005A, ea:40'h000000007F, ed:40'h0000002211};
    tbl[5] = '{cmd:8'h00, n:3, ne:3, d:32'h00030201, ea:40'h0000020100, ed:40'h0000030201};
    tbl[6] = '{cmd:8'h80, n:0, ne:1, d:32'h00000000, ea:40'h0000000000, ed:40'h0000000001};

    repeat (2) @(negedge sclk);
    chk("rst_rx_rd",    32'(bus.rx_rd_o),     32'd0);
    chk("rst_tx_wr",    32'(bus.tx_wr_o),     32'd0);
    chk("rst_reg_we",   32'(bus.reg_we_o),    32'd0);
    chk("rst_reg_re",   32'(bus.reg_re_o),    32'd0);
    chk("rst_addr",     32'(bus.reg_addr_o),  32'd0);
    chk("rst_wdata",    32'(bus.reg_wdata_o), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data_o),   32'd0);
    chk("rst_frm_cnt",  32'(bus.frm_cnt_o),   32'd0);
    rst = 1'b0;

    // Directed frames, with random FIFO gaps and backpressure.
    gap_pct = 20; full_pct = 20;
    for (int r = 0; r < NVEC; r++) begin
      body.delete();
      for (int i = 0; i < tbl[r].n; i++) body.push_back(tbl[r].d[i]);
      for (int i = 0; i < tbl[r].ne; i++) begin
        if (tbl[r].cmd[7]) begin
          exp_ra.push_back(tbl[r].ea[i]);
          exp_tx.push_back(tbl[r].ed[i]);
        end else begin
          exp_wa.push_back(tbl[r].ea[i]);
          exp_wd.push_back(tbl[r].ed[i]);
          mregs[tbl[r].ea[i][ADDR_W-1:0]] = tbl[r].ed[i];
        end
      end
      run_frame(tbl[r].cmd, body);
    end

    // TX backpressure held for five cycles in the push state.
    gap_pct = 0; full_pct = 0; full_ctl = 1'b0;
    model_frame(8'h85, 0, body);
    bpval = mregs[5];
    rxq.push_back(8'h85);
    cs_ctl = 1'b1;
    frm_exp++;
    for (int k = 0; k < 20 && !bus.reg_re_o; k++) cycle();
    chk("bp_re_seen", 32'(bus.reg_re_o), 32'd1);
    full_ctl = 1'b1;
    cycle();
    p0 = tx_pushes;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_no_push", 32'(bus.tx_wr_o), 32'd0);
      chk("bp_data_hold", 32'(bus.tx_data_o), 32'(bpval));
    end
    full_ctl = 1'b0;
    cycle();
    chk("bp_push_after", 32'(bus.tx_wr_o), 32'd1);
    repeat (3) cycle();
    chk("bp_push_count", 32'(tx_pushes - p0), 32'd1);
    cs_ctl = 1'b0;
    repeat (2) cycle();
    chk("bp_frm_cnt", 32'(bus.frm_cnt_o), 32'(frm_exp));
    rxq.delete();

    // Chip select drops while the first data byte is being written.
    rxq.push_back(8'h30); rxq.push_back(8'h99); rxq.push_back(8'h98);
    p0 = rx_pops;
    cs_ctl = 1'b1;
    for (int k = 0; k < 30 && (rx_pops - p0) < 2; k++) cycle();
    chk("abort_pops", 32'(rx_pops - p0), 32'd2);
    cs_ctl = 1'b0;
    cycle();
    chk("abort_no_we", 32'(bus.reg_we_o), 32'd0);
    frm_exp++;
    cycle();
    chk("abort_idle_no_rd", 32'(bus.rx_rd_o), 32'd0);
    chk("abort_frm_cnt", 32'(bus.frm_cnt_o), 32'(frm_exp));
    rxq.delete();
    body.delete(); body.push_back(8'h66);
    exp_wa.push_back(8'h40); exp_wd.push_back(8'h66); mregs[8'h40] = 8'h66;
    run_frame(8'h40, body);

    // Reset in the middle of a read burst.
    model_frame(8'h85, 2, body);
    rxq.push_back(8'h85);
    foreach (body[i]) rxq.push_back(body[i]);
    p0 = tx_pushes;
    cs_ctl = 1'b1;
    for (int k = 0; k < 60 && tx_pushes == p0; k++) cycle();
    chk("rstmid_push_seen", 32'(tx_pushes - p0), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_rx_rd",   32'(bus.rx_rd_o),     32'd0);
    chk("rstmid_tx_wr",   32'(bus.tx_wr_o),     32'd0);
    chk("rstmid_reg_re",  32'(bus.reg_re_o),    32'd0);
    chk("rstmid_reg_we",  32'(bus.reg_we_o),    32'd0);
    chk("rstmid_addr",    32'(bus.reg_addr_o),  32'd0);
    chk("rstmid_tx_data", 32'(bus.tx_data_o),   32'd0);
    chk("rstmid_wdata",   32'(bus.reg_wdata_o), 32'd0);
    chk("rstmid_frm_cnt", 32'(bus.frm_cnt_o),   32'd0);
    cs_ctl = 1'b0;
    rxq.delete();
    clear_expect();
    repeat (2) cycle();
    rst = 1'b0;
    frm_exp = 0;
    cycle();
    chk("post_rst_frm_cnt", 32'(bus.frm_cnt_o), 32'd0);
    body.delete(); body.push_back(8'h5E);
    exp_wa.push_back(8'h01); exp_wd.push_back(8'h5E); mregs[1] = 8'h5E;
    run_frame(8'h01, body);

    // Randomised frames against the reference model.
    gap_pct = 30; full_pct = 30;
    repeat (25) begin
      cmd = 8'($urandom);
      n = cmd[7] ? int'($urandom_range(3)) : int'($urandom_range(4, 1));
      model_frame(cmd, n, body);
      run_frame(cmd, body);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
